// File: rtl/ptr_sync_gray.sv
`default_nettype none
// ============================================================================
// Module   : ptr_sync_gray
// Brief    : Multi-stage synchroniser for a Gray-coded FIFO pointer, with
//            registered binary conversion, modular delta, change strobe and a
//            sticky Gray-violation flag. Optional macro PTR_SYNC_ERR_CNT_EN
//            adds an 8-bit saturating violation counter on o_Err_Cnt.
// Revision : 1.0 - initial release
// ============================================================================
module ptr_sync_gray #(
  parameter int              WIDTH   = 8,
  parameter int              STAGES  = 2,
  parameter logic [WIDTH:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH:0]   i_Ptr_Gray,
  input  logic             i_Err_Clr,
  output logic [WIDTH:0]   o_Sync_Ptr_Gray,
  output logic [WIDTH:0]   o_Sync_Ptr_Bin,
  output logic [WIDTH:0]   o_Ptr_Delta,
  output logic             o_Ptr_Changed,
  output logic             o_Gray_Err
`ifdef PTR_SYNC_ERR_CNT_EN
  ,
  output logic [7:0]       o_Err_Cnt
`endif
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("ptr_sync_gray: STAGES must lie in 2..4");
  end

  localparam logic [WIDTH:0] C_ONE = (WIDTH+1)'(1);

  function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
    logic [WIDTH:0] b;
    b[WIDTH] = g[WIDTH];
    for (int i = WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pure flop chain: nothing may sit between these stages.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [WIDTH:0] sync_q [STAGES];
  logic [WIDTH:0] sync_d [STAGES];

  logic [WIDTH:0] prev_q, prev_d;
  logic [WIDTH:0] bin_q, bin_d;
  logic [WIDTH:0] delta_q, delta_d;
  logic           changed_q, changed_d;
  logic           err_q, err_d;

  logic [WIDTH:0] sync_now;
  logic [WIDTH:0] diff;
  logic           viol;

  always_comb begin
    sync_d[0] = i_Ptr_Gray;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // A nonzero diff that is not a power of two has more than one bit set.
  always_comb begin
    sync_now  = sync_q[STAGES-1];
    diff      = sync_now ^ prev_q;
    viol      = |(diff & (diff - C_ONE));
    prev_d    = sync_now;
    bin_d     = gray2bin(sync_now);
    delta_d   = gray2bin(sync_now) - gray2bin(prev_q);
    changed_d = |diff;
    err_d     = viol | (err_q & ~i_Err_Clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
      prev_q    <= RST_VAL;
      bin_q     <= gray2bin(RST_VAL);
      delta_q   <= '0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      prev_q    <= prev_d;
      bin_q     <= bin_d;
      delta_q   <= delta_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign o_Sync_Ptr_Gray = sync_q[STAGES-1];
  assign o_Sync_Ptr_Bin  = bin_q;
  assign o_Ptr_Delta     = delta_q;
  assign o_Ptr_Changed   = changed_q;
  assign o_Gray_Err      = err_q;

`ifdef PTR_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A new event during a clear restarts the count at one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (viol) begin
      if (i_Err_Clr) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (i_Err_Clr) begin
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_Err_Cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ptr_sync_gray.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for ptr_sync_gray: two instances (STAGES=2/RST 0 and STAGES=3/RST 5)
// checked against a sample-history reference model through per-instance queues.
module tb_ptr_sync_gray;
  localparam int W = 8;
  localparam int STG_A = 2;
  localparam int STG_B = 3;
  localparam logic [W:0] RST_A = 9'h000;
  localparam logic [W:0] RST_B = 9'h005;

  typedef struct packed {
    logic [W:0] sync;
    logic [W:0] bin;
    logic [W:0] delta;
    logic       changed;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [W:0] ptr;
  logic       clr_a, clr_b;

  logic [W:0] a_sync, a_bin, a_delta, b_sync, b_bin, b_delta;
  logic       a_chg, a_err, b_chg, b_err;
  logic [7:0] a_cnt, b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [W:0] hist [2][8];
  logic       m_err [2];
  int         m_cnt [2];

  ptr_sync_gray #(.WIDTH(W), .STAGES(STG_A), .RST_VAL(RST_A)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_Ptr_Gray(ptr), .i_Err_Clr(clr_a),
    .o_Sync_Ptr_Gray(a_sync), .o_Sync_Ptr_Bin(a_bin), .o_Ptr_Delta(a_delta),
    .o_Ptr_Changed(a_chg), .o_Gray_Err(a_err)
`ifdef PTR_SYNC_ERR_CNT_EN
    , .o_Err_Cnt(a_cnt)
`endif
  );

  ptr_sync_gray #(.WIDTH(W), .STAGES(STG_B), .RST_VAL(RST_B)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_Ptr_Gray(ptr), .i_Err_Clr(clr_b),
    .o_Sync_Ptr_Gray(b_sync), .o_Sync_Ptr_Bin(b_bin), .o_Ptr_Delta(b_delta),
    .o_Ptr_Changed(b_chg), .o_Gray_Err(b_err)
`ifdef PTR_SYNC_ERR_CNT_EN
    , .o_Err_Cnt(b_cnt)
`endif
  );

`ifndef PTR_SYNC_ERR_CNT_EN
  assign a_cnt = 8'd0;
  assign b_cnt = 8'd0;
`endif

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  // Binary value of a Gray code: XOR of all right shifts.
  function automatic logic [W:0] g2b(input logic [W:0] g);
    logic [W:0] b;
    b = '0;
    for (int k = 0; k <= W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  // hist[d][k] is the pointer sampled k edges ago; the synced value is the
  // sample STAGES-1 edges old, so the outputs relate to older history entries.
  task automatic model_step(input int d, input logic r, input logic [W:0] p,
                            input logic c, output exp_t e);
    int stg;
    logic [W:0] rv, s_now, s_cur, s_old;
    logic viol;
    stg = (d == 0) ? STG_A : STG_B;
    rv  = (d == 0) ? RST_A : RST_B;
    if (r) begin
      for (int k = 0; k < 8; k++) hist[d][k] = rv;
      m_err[d] = 1'b0;
      m_cnt[d] = 0;
      e.sync = rv; e.bin = g2b(rv); e.delta = '0;
      e.changed = 1'b0; e.err = 1'b0; e.cnt = 8'd0;
    end else begin
      for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0] = p;
      s_now = hist[d][stg-1];
      s_cur = hist[d][stg];
      s_old = hist[d][stg+1];
      viol  = $countones(s_cur ^ s_old) > 1;
      if (viol) begin
        m_err[d] = 1'b1;
        m_cnt[d] = c ? 1 : ((m_cnt[d] < 255) ? m_cnt[d] + 1 : 255);
      end else if (c) begin
        m_err[d] = 1'b0;
        m_cnt[d] = 0;
      end
      e.sync    = s_now;
      e.bin     = g2b(s_cur);
      e.delta   = g2b(s_cur) - g2b(s_old);
      e.changed = (s_cur != s_old);
      e.err     = m_err[d];
      e.cnt     = m_cnt[d][7:0];
    end
  endtask

  task automatic cycle(input logic r, input logic [W:0] p, input logic ca, input logic cb);
    exp_t e;
    rst = r; ptr = p; clr_a = ca; clr_b = cb;
    model_step(0, r, p, ca, e); q_a.push_back(e);
    model_step(1, r, p, cb, e); q_b.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input logic [W:0] s,
                           input logic [W:0] b, input logic [W:0] dl,
                           input logic ch, input logic er, input logic [7:0] cn);
    chk({tag, ".sync"},    s,  e.sync);
    chk({tag, ".bin"},     b,  e.bin);
    chk({tag, ".delta"},   dl, e.delta);
    chk({tag, ".changed"}, {8'd0, ch}, {8'd0, e.changed});
    chk({tag, ".err"},     {8'd0, er}, {8'd0, e.err});
`ifdef PTR_SYNC_ERR_CNT_EN
    chk({tag, ".cnt"},     {1'b0, cn}, {1'b0, e.cnt});
`else
    if (cn !== 8'd0) chk({tag, ".cnt_tie"}, {1'b0, cn}, 9'd0);
`endif
  endtask

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_dut("A", e, a_sync, a_bin, a_delta, a_chg, a_err, a_cnt);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_dut("B", e, b_sync, b_bin, b_delta, b_chg, b_err, b_cnt);
      end
    end
  end

  initial begin
    logic [W:0] cur, v;
    int r;
    // Reset, then a single step 000 -> 001.
    for (int i = 0; i < 3; i++) cycle(1'b1, 9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 9'h001, 1'b0, 1'b0);

    // Reset value 005 on B, then 007 (binary 5, delta 0x1FF).
    for (int i = 0; i < 3; i++) cycle(1'b1, 9'h005, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 9'h007, 1'b0, 1'b0);

    // Full Gray count including the wrap 0x100 -> 0x000.
    for (int i = 0; i < 3; i++) cycle(1'b1, 9'h000, 1'b0, 1'b0);
    for (int i = 0; i <= 512; i++) begin
      v = i[W:0];
      cycle(1'b0, v ^ (v >> 1), 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);

    // Two-bit jump, then clear, then violation coinciding with clear.
    for (int i = 0; i < 5; i++) cycle(1'b0, 9'h003, 1'b0, 1'b0);
    cycle(1'b0, 9'h003, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 9'h003, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 9'h000, i == 2, i == 3);

    // Reset while a new value is in flight.
    cycle(1'b0, 9'h001, 1'b0, 1'b0);
    cycle(1'b1, 9'h001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);

    // 300+ violations for counter saturation, then clear variants.
    for (int i = 0; i < 302; i++) cycle(1'b0, (i % 2 == 0) ? 9'h003 : 9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);
    cycle(1'b0, 9'h000, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 9'h003, i == 2, i == 3);

    // Randomised mix: mostly legal single-bit steps.
    cur = 9'h003;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80) cur = cur ^ (9'h001 << $urandom_range(0, W));
      else if (r < 95) cur = cur;
      else cur = 9'($urandom_range(0, 511));
      cycle($urandom_range(0, 99) < 2, cur, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 5);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
